apple_shadow_writer: RTL and testbench
======================================

# apple_shadow_writer

Buffered, parametrised writer that captures Apple II bus writes to video regions and drains them, as 32-bit byte-enabled beats, to a shared shadow memory that can stall (SDRAM/arbitrated BSRAM). It sits between the bus capture logic (which supplies the main/aux select) and the memory controller. Unlike the BRAM-direct shadow path, it absorbs back-pressure in a FIFO, reports overflow, and optionally maps 32 KB of hires per bank.

## Interface
- MEM_ADDR_WIDTH, 15: word address width of the shadow memory; must be >= 15.
- FIFO_DEPTH, 8: queue entries; power of 2, 2..64.
- HIRES_32K, 1: 1 maps $2000-$9FFF per bank; 0 maps $2000-$5FFF only.

- clk_logic  in  1  system logic clock.
- system_reset_n  in  1  asynchronous, active-low reset.
- wr_strobe_i  in  1  one-cycle pulse: valid bus write this cycle.
- addr_i  in  16  Apple II bus address.
- data_i  in  8  write data.
- aux_i  in  1  1 = aux bank (E1), 0 = main.
- mem_we_o  out  1  beat valid.
- mem_addr_o  out  MEM_ADDR_WIDTH  word address.
- mem_wdata_o  out  32  data replicated or merged per lane.
- mem_be_o  out  4  byte enables.
- mem_ready_i  in  1  memory accepts beat when high with mem_we_o.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  queued entries (excluding output beat).
- overflow_o  out  1  sticky: a write was dropped.
- overflow_clr_i  in  1  clears overflow_o.

## Operation
- Byte-address map (B): text $0400-$0BFF -> B = (A-$0400) + (aux ? $00800 : 0); hires -> B = $08000 + (A-$2000) + (aux ? $08000 : 0). Word addr = B[16:2], zero-extended to MEM_ADDR_WIDTH; lane = B[1:0].
- Writes outside mapped windows (including $6000-$9FFF when HIRES_32K=0) are ignored: no push, no overflow.
- Push: mapped wr_strobe_i enqueues {word addr, lane, data}.
- Output register: when empty (or accepted this cycle) and FIFO non-empty, loads head; mem_wdata_o = data replicated to all 4 lanes, mem_be_o = 1 << lane.
- Handshake: beat transfers on clock edge with mem_we_o && mem_ready_i. mem_we_o, addr, data, be hold stable until transfer. mem_we_o never drops without transfer.
- Full: push when FIFO full and no pop that cycle -> dropped, overflow_o set. Push and pop in same cycle at full -> push accepted.
- Empty: push into empty FIFO with output register empty still passes through FIFO (no bypass).
- overflow_clr_i and a simultaneous overflow: set wins.
- Order preserved; no reordering between banks.

## Timing
- Reset: mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0, fifo_level_o=0, overflow_o=0; FIFO pointers cleared. Reset mid-transfer discards queued and pending beats.
- Latency: strobe at edge N -> entry visible at N+1 (fifo_level_o=1) -> mem_we_o high after edge N+2 with ready held high.
- Throughput: one beat per cycle with mem_ready_i high; sustained bus write rate (≤1 per ~14 clk_logic) never overflows unless ready stalls > FIFO_DEPTH writes.
- Pointer arithmetic: $clog2(FIFO_DEPTH)+1 bits, wrap-around by MSB toggle; full when addresses equal and MSBs differ.

## Configuration
- SHADOW_COALESCE_EN defined: while the output beat is pending (mem_we_o=1, not accepted), a FIFO head with the same word address is popped and merged into it: lane byte written, be OR-ed; same lane overwritten (later wins). Merge counts as a pop for level/full.
- Undefined: every queued write becomes exactly one beat with one-hot mem_be_o; no merging.

## Test plan
- Reset then single write A=$0400, D=$A5, aux=0, ready=1 -> one beat: addr=0, be=4'b0001, wdata=$A5A5A5A5, at N+2.
- Write A=$2001, D=$3C, aux=1 -> addr=$4000 (B=$10001), be=4'b0010; A=$6000 with HIRES_32K=0 -> no beat, level 0, overflow 0.
- ready=0, FIFO_DEPTH+2 writes -> level=FIFO_DEPTH, overflow_o=1, first beat held stable; release ready -> FIFO_DEPTH+1 beats in order; overflow_clr_i -> 0.
- ready=0, writes $0400=$11, $0401=$22, $0403=$44 -> with SHADOW_COALESCE_EN one beat be=4'b1011, wdata[7:0]=$11,[15:8]=$22,[31:24]=$44; without, three beats.
- Assert system_reset_n low while mem_we_o=1 and level=3 -> all outputs 0 immediately; after release no stale beats.
- Full FIFO, ready=1, push same cycle as pop -> push accepted, overflow_o stays 0.

Source files
------------

// File: rtl/apple_shadow_writer.sv
// Buffered Apple II video-write shadow writer: maps bus writes into a FIFO and drains byte-enabled 32-bit beats.
// Optional SHADOW_COALESCE_EN merges same-word FIFO heads into a stalled output beat.
module apple_shadow_writer #(
  parameter int MEM_ADDR_WIDTH = 15,
  parameter int FIFO_DEPTH     = 8,
  parameter bit HIRES_32K      = 1'b1
) (
  input  logic                          clk_logic,
  input  logic                          system_reset_n,
  input  logic                          wr_strobe_i,
  input  logic [15:0]                   addr_i,
  input  logic [7:0]                    data_i,
  input  logic                          aux_i,
  output logic                          mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [31:0]                   mem_wdata_o,
  output logic [3:0]                    mem_be_o,
  input  logic                          mem_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overflow_o,
  input  logic                          overflow_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = 17 + 8;

  logic                      r_we;
  logic [MEM_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_be;
  logic                      r_overflow;
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [EW-1:0]             r_fifo [FIFO_DEPTH];

  logic          w_in_text;
  logic          w_in_hires;
  logic          w_push;
  logic [16:0]   w_byte_addr;
  logic [EW-1:0] w_entry;
  logic [EW-1:0] w_head;
  logic [14:0]   w_head_addr;
  logic [1:0]    w_head_lane;
  logic [7:0]    w_head_data;
  logic [3:0]    w_lane_onehot;
  logic [PW-1:0] w_level;
  logic          w_empty;
  logic          w_full;
  logic          w_out_free;
  logic          w_load;
  logic          w_merge;
  logic          w_pop;
  logic          w_push_ok;
  logic          w_drop;

  assign w_in_text  = (addr_i >= 16'h0400) && (addr_i <= 16'h0BFF);
  assign w_in_hires = (addr_i >= 16'h2000) &&
                      (HIRES_32K ? (addr_i <= 16'h9FFF) : (addr_i <= 16'h5FFF));

  // Text pages sit at byte 0 (aux +$800); hires starts at $8000 (aux +$8000).
  always_comb begin
    w_byte_addr = '0;
    if (w_in_text) begin
      w_byte_addr = {1'b0, addr_i} - 17'h00400 + (aux_i ? 17'h00800 : 17'h00000);
    end else if (w_in_hires) begin
      w_byte_addr = {1'b0, addr_i} - 17'h02000 + 17'h08000 + (aux_i ? 17'h08000 : 17'h00000);
    end
  end

  assign w_push  = wr_strobe_i && (w_in_text || w_in_hires);
  assign w_entry = {w_byte_addr, data_i};

  assign w_head        = r_fifo[r_rd_ptr[AW-1:0]];
  assign w_head_addr   = w_head[24:10];
  assign w_head_lane   = w_head[9:8];
  assign w_head_data   = w_head[7:0];
  assign w_lane_onehot = 4'b0001 << w_head_lane;

  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  assign w_out_free = !r_we || mem_ready_i;
  assign w_load     = w_out_free && !w_empty;

`ifdef SHADOW_COALESCE_EN
  assign w_merge = r_we && !mem_ready_i && !w_empty &&
                   (MEM_ADDR_WIDTH'(w_head_addr) == r_addr);
`else
  assign w_merge = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign w_pop     = w_load || w_merge;
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  always_ff @(posedge clk_logic) begin
    if (w_push_ok) begin
      r_fifo[r_wr_ptr[AW-1:0]] <= w_entry;
    end
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_load) begin
      r_we    <= 1'b1;
      r_addr  <= MEM_ADDR_WIDTH'(w_head_addr);
      r_wdata <= {4{w_head_data}};
      r_be    <= w_lane_onehot;
    end else if (w_merge) begin
      r_wdata[{w_head_lane, 3'b000} +: 8] <= w_head_data;
      r_be                                <= r_be | w_lane_onehot;
    end else if (r_we && mem_ready_i) begin
      r_we <= 1'b0;
    end
  end

  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_be_o     = r_be;
  assign fifo_level_o = w_level;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_apple_shadow_writer.sv
// Self-checking bench for apple_shadow_writer: directed scenarios plus randomized traffic
// compared against an address-map reference model and an expected-beat queue.
`timescale 1ns/1ps
module tb_apple_shadow_writer;
  localparam int MAW   = 15;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic strobe = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0] data = '0;
  logic aux = 1'b0;
  logic ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic we, ovf, h16_we, h16_ovf;
  logic [MAW-1:0] maddr, h16_maddr;
  logic [31:0] wdata, h16_wdata;
  logic [3:0] be, h16_be;
  logic [LW-1:0] level, h16_level;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  apple_shadow_writer #(.MEM_ADDR_WIDTH(MAW), .FIFO_DEPTH(DEPTH), .HIRES_32K(1'b1)) u_dut (
    .clk_logic(clk), .system_reset_n(rst_n), .wr_strobe_i(strobe), .addr_i(addr),
    .data_i(data), .aux_i(aux), .mem_we_o(we), .mem_addr_o(maddr), .mem_wdata_o(wdata),
    .mem_be_o(be), .mem_ready_i(ready), .fifo_level_o(level), .overflow_o(ovf),
    .overflow_clr_i(ovf_clr));

  apple_shadow_writer #(.MEM_ADDR_WIDTH(MAW), .FIFO_DEPTH(DEPTH), .HIRES_32K(1'b0)) u_dut_h16 (
    .clk_logic(clk), .system_reset_n(rst_n), .wr_strobe_i(strobe), .addr_i(addr),
    .data_i(data), .aux_i(aux), .mem_we_o(h16_we), .mem_addr_o(h16_maddr),
    .mem_wdata_o(h16_wdata), .mem_be_o(h16_be), .mem_ready_i(ready),
    .fifo_level_o(h16_level), .overflow_o(h16_ovf), .overflow_clr_i(ovf_clr));

  // Record every beat that will transfer on the coming rising edge.
  always @(negedge clk) begin
    if (rst_n && we && ready) obs_q.push_back({maddr, be, wdata});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_map(input int a, input bit ax, input bit h32, output int b);
    b = 0;
    if (a >= 'h400 && a < 'hC00) begin
      b = a - 'h400 + (ax ? 'h800 : 0);
      return 1'b1;
    end
    if (a >= 'h2000 && a < (h32 ? 'hA000 : 'h6000)) begin
      b = 'h8000 + (a - 'h2000) + (ax ? 'h8000 : 0);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void expect_beat(input int a, input int d, input bit ax);
    int b;
    beat_t t;
    if (ref_map(a, ax, 1'b1, b)) begin
      t.addr  = 15'(b / 4);
      t.be    = 4'(1 << (b % 4));
      t.wdata = {4{8'(d)}};
      exp_q.push_back(t);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d, input bit ax);
    strobe = 1'b1;
    addr   = 16'(a);
    data   = 8'(d);
    aux    = ax;
    step();
    strobe = 1'b0;
  endtask

  task automatic drain(input int n);
    ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (obs_q.size() >= n) break;
      step();
    end
    repeat (4) step();
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    total += 6;
    if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b need=0", we); end
    if (maddr !== '0) begin bad++; $display("FAIL reset_addr got=%h need=0", maddr); end
    if (wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%h need=0", wdata); end
    if (be !== '0) begin bad++; $display("FAIL reset_be got=%b need=0", be); end
    if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d need=0", level); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b need=0", ovf); end
    rst_n = 1'b1;
    step();
    $display("reset: we=%b level=%0d ovf=%b", we, level, ovf);
  endtask

  task automatic test_single();
    clear_q();
    ready = 1'b1;
    expect_beat('h400, 'hA5, 1'b0);
    wr('h400, 'hA5, 1'b0);
    total += 2;
    if (level !== LW'(1)) begin bad++; $display("FAIL single_level_n1 got=%0d need=1", level); end
    if (we !== 1'b0) begin bad++; $display("FAIL single_we_n1 got=%b need=0", we); end
    step();
    total += 4;
    if (we !== 1'b1) begin bad++; $display("FAIL single_we_n2 got=%b need=1", we); end
    if (maddr !== 15'h0) begin bad++; $display("FAIL single_addr got=%h need=0", maddr); end
    if (be !== 4'b0001) begin bad++; $display("FAIL single_be got=%b need=0001", be); end
    if (wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL single_wdata got=%h need=a5a5a5a5", wdata); end
    step();
    total++;
    if (we !== 1'b0) begin bad++; $display("FAIL single_we_after got=%b need=0", we); end
    drain(exp_q.size());
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL single_count got=%0d need=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_beat%0d got=%h need=%h", i, obs_q[i], exp_q[i]); end
    end
    $display("single: beats=%0d", obs_q.size());
  endtask

  task automatic test_map();
    int wa[8] = '{'h2001, 'hA000, 'h0BFF, 'h0C00, 'h03FF, 'h9FFF, 'h1FFF, 'h6000};
    bit wx[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    clear_q();
    ready = 1'b1;
    wr('h6000, 'h5A, 1'b0);
    expect_beat('h6000, 'h5A, 1'b0);
    total++;
    if (h16_level !== '0) begin bad++; $display("FAIL map_h16_level got=%0d need=0", h16_level); end
    step();
    total += 2;
    if (h16_we !== 1'b0) begin bad++; $display("FAIL map_h16_we got=%b need=0", h16_we); end
    if (h16_ovf !== 1'b0) begin bad++; $display("FAIL map_h16_ovf got=%b need=0", h16_ovf); end
    for (int i = 0; i < 8; i++) begin
      int d = int'($urandom_range(0, 255));
      expect_beat(wa[i], d, wx[i]);
      wr(wa[i], d, wx[i]);
      step();
    end
    drain(exp_q.size());
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL map_count got=%0d need=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL map_beat%0d got=%h need=%h", i, obs_q[i], exp_q[i]); end
    end
    $display("map: beats=%0d", obs_q.size());
  endtask

  task automatic test_overflow();
    beat_t first;
    clear_q();
    ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      int d = int'($urandom_range(0, 255));
      if (i <= DEPTH) expect_beat('h400 + 4 * i, d, 1'b0);
      wr('h400 + 4 * i, d, 1'b0);
    end
    total += 2;
    if (level !== LW'(DEPTH)) begin bad++; $display("FAIL ovf_level got=%0d need=%0d", level, DEPTH); end
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b need=1", ovf); end
    first = exp_q[0];
    for (int c = 0; c < 3; c++) begin
      total++;
      if (we !== 1'b1 || {maddr, be, wdata} !== first) begin
        bad++; $display("FAIL ovf_hold we=%b got=%h need=%h", we, {maddr, be, wdata}, first);
      end
      step();
    end
    drain(exp_q.size());
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL ovf_count got=%0d need=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_beat%0d got=%h need=%h", i, obs_q[i], exp_q[i]); end
    end
    total++;
    if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b need=1", ovf); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    total++;
    if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b need=0", ovf); end
    $display("overflow: beats=%0d", obs_q.size());
  endtask

  task automatic test_coalesce();
    int need_level;
    clear_q();
    ready = 1'b0;
    wr('h400, 'h11, 1'b0);
    wr('h401, 'h22, 1'b0);
    wr('h403, 'h44, 1'b0);
    repeat (3) step();
`ifdef SHADOW_COALESCE_EN
    exp_q.push_back({15'h0, 4'b1011, 32'h44112211});
    need_level = 0;
`else
    expect_beat('h400, 'h11, 1'b0);
    expect_beat('h401, 'h22, 1'b0);
    expect_beat('h403, 'h44, 1'b0);
    need_level = 2;
`endif
    total++;
    if (level !== LW'(need_level)) begin bad++; $display("FAIL coal_level got=%0d need=%0d", level, need_level); end
    drain(exp_q.size());
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL coal_count got=%0d need=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL coal_beat%0d got=%h need=%h", i, obs_q[i], exp_q[i]); end
    end
    $display("coalesce: beats=%0d", obs_q.size());
  endtask

  task automatic test_reset_mid();
    clear_q();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) wr('h500 + 4 * i, 'h10 + i, 1'b1);
    step();
    total += 2;
    if (we !== 1'b1) begin bad++; $display("FAIL rstmid_pre_we got=%b need=1", we); end
    if (level !== LW'(3)) begin bad++; $display("FAIL rstmid_pre_level got=%0d need=3", level); end
    #2 rst_n = 1'b0;
    #1;
    total += 5;
    if (we !== 1'b0) begin bad++; $display("FAIL rstmid_we got=%b need=0", we); end
    if (maddr !== '0) begin bad++; $display("FAIL rstmid_addr got=%h need=0", maddr); end
    if (wdata !== '0) begin bad++; $display("FAIL rstmid_wdata got=%h need=0", wdata); end
    if (be !== '0) begin bad++; $display("FAIL rstmid_be got=%b need=0", be); end
    if (level !== '0) begin bad++; $display("FAIL rstmid_level got=%0d need=0", level); end
    step();
    rst_n = 1'b1;
    clear_q();
    drain(0);
    total += 2;
    if (obs_q.size() != 0) begin bad++; $display("FAIL rstmid_stale got=%0d beats need=0", obs_q.size()); end
    if (level !== '0) begin bad++; $display("FAIL rstmid_level_after got=%0d need=0", level); end
    $display("reset_mid: stale beats=%0d", obs_q.size());
  endtask

  task automatic test_full_pushpop();
    clear_q();
    ready = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      int d = int'($urandom_range(0, 255));
      expect_beat('h800 + 4 * i, d, 1'b0);
      wr('h800 + 4 * i, d, 1'b0);
    end
    total += 2;
    if (level !== LW'(DEPTH)) begin bad++; $display("FAIL full_level got=%0d need=%0d", level, DEPTH); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL full_ovf_pre got=%b need=0", ovf); end
    ready = 1'b1;
    expect_beat('h900, 'hC3, 1'b1);
    wr('h900, 'hC3, 1'b1);
    total += 2;
    if (ovf !== 1'b0) begin bad++; $display("FAIL full_pushpop_ovf got=%b need=0", ovf); end
    if (level !== LW'(DEPTH)) begin bad++; $display("FAIL full_pushpop_level got=%0d need=%0d", level, DEPTH); end
    drain(exp_q.size());
    total++;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL full_count got=%0d need=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL full_beat%0d got=%h need=%h", i, obs_q[i], exp_q[i]); end
    end
    $display("full_pushpop: beats=%0d", obs_q.size());
  endtask

  task automatic test_random();
    int pushes = 0;
    int last_word = -1;
    clear_q();
    for (int c = 0; c < 400; c++) begin
      int a, b, d;
      bit ax, go, mapped, pend;
      beat_t prev;
      case ($urandom_range(0, 3))
        0: a = 'h400 + int'($urandom_range(0, 'h7FF));
        1: a = 'h2000 + int'($urandom_range(0, 'h7FFF));
        2: a = int'($urandom_range(0, 'h3FF));
        default: a = 'hA000 + int'($urandom_range(0, 'h5FFF));
      endcase
      ax = 1'($urandom_range(0, 1));
      d = int'($urandom_range(0, 255));
      mapped = ref_map(a, ax, 1'b1, b);
      go = ($urandom_range(0, 1) == 1);
      if (mapped && ((pushes - obs_q.size()) >= DEPTH || b / 4 == last_word)) go = 1'b0;
      ready = ($urandom_range(0, 3) != 0);
      pend = we && !ready;
      prev = {maddr, be, wdata};
      if (go) begin
        if (mapped) begin pushes++; last_word = b / 4; end
        expect_beat(a, d, ax);
        strobe = 1'b1; addr = 16'(a); data = 8'(d); aux = ax;
      end
      step();
      strobe = 1'b0;
      if (pend) begin
        total++;
        if (we !== 1'b1 || {maddr, be, wdata} !== prev) begin
          bad++; $display("FAIL rand_hold cyc=%0d we=%b got=%h need=%h", c, we, {maddr, be, wdata}, prev);
        end
      end
    end
    drain(exp_q.size());
    total += 2;
    if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d need=%0d", obs_q.size(), exp_q.size()); end
    if (ovf !== 1'b0) begin bad++; $display("FAIL rand_ovf got=%b need=0", ovf); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand_beat%0d got=%h need=%h", i, obs_q[i], exp_q[i]); end
    end
    $display("random: pushes=%0d beats=%0d", pushes, obs_q.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_map();
    test_overflow();
    test_coalesce();
    test_reset_mid();
    test_full_pushpop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
